// File: rtl/input_event_ctrl.sv
// Input peripheral for the 0x7800-0x781F I/O window: synchronized switches,
// per-button debounce FSMs, sticky W1C press events and a maskable interrupt.
module input_event_ctrl #(
   parameter int unsigned     NUM_BTN    = 4,
   parameter int unsigned     DB_W       = 16,
   parameter logic [DB_W-1:0] DEFAULT_DB = 16'd1000
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [15:0]        i_addr,
   input  logic               i_st_en,
   input  logic [31:0]        i_st_data,
   input  logic [31:0]        io_sw_i,
   input  logic [NUM_BTN-1:0] io_btn_i,
   output logic [31:0]        o_ld_data,
   output logic               o_irq
);

   localparam logic [10:0] WIN_BASE   = 11'h3C0;
   localparam logic [2:0]  OFF_SW     = 3'd0;
   localparam logic [2:0]  OFF_LEVEL  = 3'd4;
   localparam logic [2:0]  OFF_EVENT  = 3'd5;
   localparam logic [2:0]  OFF_IRQ_EN = 3'd6;
   localparam logic [2:0]  OFF_DB     = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_PRESS_CHK = 2'd1,
      S_HELD      = 2'd2,
      S_REL_CHK   = 2'd3
   } state_t;

   logic [31:0]        sw_meta_q, sw_sync_q;
   logic [NUM_BTN-1:0] btn_meta_q, btn_sync_q;
   logic [NUM_BTN-1:0] level_s, ev_set_s;
   logic [NUM_BTN-1:0] event_q, event_d;
   logic [NUM_BTN-1:0] irq_en_q, irq_en_d;
   logic [NUM_BTN-1:0] w1c_mask_s;
   logic [DB_W-1:0]    db_q, db_d, lim_s;
   logic [31:0]        ld_data_q, ld_data_d;
   logic               irq_q, irq_d;
   logic               in_win_s, wr_event_s, wr_irq_en_s, wr_db_s;
   logic               unused_s;

   // Byte-lane bits and upper store bits carry no meaning for this block.
   assign unused_s = ^{i_addr[1:0], i_st_data};

   // Two-flop synchronizers for the asynchronous switch and button inputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sw_meta_q  <= 32'd0;
         sw_sync_q  <= 32'd0;
         btn_meta_q <= {NUM_BTN{1'b0}};
         btn_sync_q <= {NUM_BTN{1'b0}};
      end else begin
         sw_meta_q  <= io_sw_i;
         sw_sync_q  <= sw_meta_q;
         btn_meta_q <= io_btn_i;
         btn_sync_q <= btn_meta_q;
      end
   end

   // Store decode for the writable registers.
   always_comb begin
      in_win_s    = (i_addr[15:5] == WIN_BASE);
      wr_event_s  = 1'b0;
      wr_irq_en_s = 1'b0;
      wr_db_s     = 1'b0;
      if (i_st_en && in_win_s) begin
         case (i_addr[4:2])
            OFF_EVENT:  wr_event_s  = 1'b1;
            OFF_IRQ_EN: wr_irq_en_s = 1'b1;
            OFF_DB:     wr_db_s     = 1'b1;
            default: begin
               wr_event_s  = 1'b0;
               wr_irq_en_s = 1'b0;
               wr_db_s     = 1'b0;
            end
         endcase
      end else begin
         wr_event_s = 1'b0;
      end
   end

   // A debounce value of zero behaves as one, so the limit floors at zero.
   always_comb begin
      if (db_q == {DB_W{1'b0}}) begin
         lim_s = {DB_W{1'b0}};
      end else begin
         lim_s = db_q - {{(DB_W-1){1'b0}}, 1'b1};
      end
   end

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      state_t          state_q, state_d;
      logic [DB_W-1:0] cnt_q, cnt_d, cnt_inc_s;
      logic            btn_s, done_s, level_b, ev_b;

      assign btn_s     = btn_sync_q[g];
      assign done_s    = (cnt_q >= lim_s);
      assign cnt_inc_s = (&cnt_q) ? cnt_q : cnt_q + {{(DB_W-1){1'b0}}, 1'b1};

      // Debounce state and counter registers.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {DB_W{1'b0}};
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      // Debounce next-state: a level must hold for the full limit to be accepted.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         case (state_q)
            S_IDLE: begin
               if (btn_s) begin
                  state_d = S_PRESS_CHK;
                  cnt_d   = {DB_W{1'b0}};
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_PRESS_CHK: begin
               if (!btn_s) begin
                  state_d = S_IDLE;
               end else if (done_s) begin
                  state_d = S_HELD;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
            S_HELD: begin
               if (!btn_s) begin
                  state_d = S_REL_CHK;
                  cnt_d   = {DB_W{1'b0}};
               end else begin
                  state_d = S_HELD;
               end
            end
            S_REL_CHK: begin
               if (btn_s) begin
                  state_d = S_HELD;
               end else if (done_s) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = {DB_W{1'b0}};
            end
         endcase
      end

      // Debounce outputs: level follows the state, the event pulses on press acceptance.
      always_comb begin
         level_b = 1'b0;
         ev_b    = 1'b0;
         case (state_q)
            S_PRESS_CHK:       ev_b    = btn_s && done_s;
            S_HELD, S_REL_CHK: level_b = 1'b1;
            default: begin
               level_b = 1'b0;
               ev_b    = 1'b0;
            end
         endcase
      end

      assign level_s[g]  = level_b;
      assign ev_set_s[g] = ev_b;
   end

   assign w1c_mask_s = wr_event_s ? i_st_data[NUM_BTN-1:0] : {NUM_BTN{1'b0}};

   // Register next-state; a new event outranks a same-cycle clear.
   always_comb begin
      event_d  = (event_q & ~w1c_mask_s) | ev_set_s;
      irq_en_d = wr_irq_en_s ? i_st_data[NUM_BTN-1:0] : irq_en_q;
      db_d     = wr_db_s ? i_st_data[DB_W-1:0] : db_q;
      irq_d    = |(event_q & irq_en_q);
   end

   // Read mux sees pre-store register contents.
   always_comb begin
      ld_data_d = 32'd0;
      if (in_win_s) begin
         case (i_addr[4:2])
            OFF_SW:     ld_data_d                = sw_sync_q;
            OFF_LEVEL:  ld_data_d[NUM_BTN-1:0]   = level_s;
            OFF_EVENT:  ld_data_d[NUM_BTN-1:0]   = event_q;
            OFF_IRQ_EN: ld_data_d[NUM_BTN-1:0]   = irq_en_q;
            OFF_DB:     ld_data_d[DB_W-1:0]      = db_q;
            default:    ld_data_d                = 32'd0;
         endcase
      end else begin
         ld_data_d = 32'd0;
      end
   end

   // Control/status registers and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         event_q   <= {NUM_BTN{1'b0}};
         irq_en_q  <= {NUM_BTN{1'b0}};
         db_q      <= DEFAULT_DB;
         ld_data_q <= 32'd0;
         irq_q     <= 1'b0;
      end else begin
         event_q   <= event_d;
         irq_en_q  <= irq_en_d;
         db_q      <= db_d;
         ld_data_q <= ld_data_d;
         irq_q     <= irq_d;
      end
   end

   assign o_ld_data = ld_data_q;
   assign o_irq     = irq_q;

endmodule

// File: doc/input_event_ctrl.md
Name: input_event_ctrl

Overview:
Memory-mapped input peripheral controller for the single-cycle core's I/O window 0x7800–0x781F. It synchronizes the slide switches and sequences per-button debounce state machines. Debounced press events are latched into a sticky write-1-to-clear register, with a maskable interrupt. The LSU reads this block's registers with one-cycle registered read data.

Parameters:
NUM_BTN, 4, number of push buttons (1–8)
DB_W, 16, debounce counter / config register width
DEFAULT_DB, 16'd1000, reset value of the debounce register (cycles)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_addr  in  16  LSU byte address
i_st_en  in  1  store strobe, one cycle per store
i_st_data  in  32  store data
io_sw_i  in  32  raw switches, asynchronous
io_btn_i  in  NUM_BTN  raw buttons, active-high, asynchronous
o_ld_data  out  32  registered read data
o_irq  out  1  registered interrupt request

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is i_clk. All flops clear on reset: sync flops, FSMs to IDLE, counters, level, event, irq_en, o_ld_data=0, o_irq=0. The debounce register resets to DEFAULT_DB. A reset mid-debounce discards the count; no event is generated.
- Synchronizers: io_sw_i and io_btn_i each pass through 2-FF synchronizers. sw_sync and btn_sync are valid 2 edges after the raw change.
- Register map (word-aligned, bits [1:0] ignored):
  - 0x7800 SW: read-only, sw_sync.
  - 0x7810 BTN_LEVEL: read-only, debounced levels in [NUM_BTN-1:0].
  - 0x7814 BTN_EVENT: sticky press flags. Writing 1 to a bit clears it; writing 0 has no effect.
  - 0x7818 IRQ_EN: read/write, [NUM_BTN-1:0].
  - 0x781C DEBOUNCE: read/write, [DB_W-1:0].
  - Other addresses in 0x7800–0x781F read 0. Addresses outside the window read 0; stores there are ignored.
  - Unused upper bits read 0.
- Read timing: o_ld_data is registered from the address present at the clock edge, so data is visible the cycle after i_addr is presented. A same-cycle store does not affect that read value; the read returns the pre-store register contents.
- Per-button FSM (independent instance per button). Let eff_db = max(DEBOUNCE, 1).
  - IDLE: btn_sync=1 → PRESS_CHK, cnt=0.
  - PRESS_CHK: btn_sync=0 → IDLE. Else if cnt ≥ eff_db-1 → HELD, level=1, set event bit. Else cnt++.
  - HELD: btn_sync=0 → REL_CHK, cnt=0.
  - REL_CHK: btn_sync=1 → HELD with no new event. Else if cnt ≥ eff_db-1 → IDLE, level=0. Else cnt++.
- Latency: a clean rising input changed before edge 1 produces level=1 and the event bit at edge 3+eff_db. Release behaves symmetrically for level; release never generates an event.
- Comparison is ≥, so shrinking DEBOUNCE mid-count forces the transition on the next edge. Growing it extends the count. The counter saturates and never wraps.
- Simultaneous event set and W1C on the same bit in the same cycle: set wins, bit stays 1.
- o_irq = registered |(event & irq_en), updated every edge, one cycle after the contributing change.
- No bus stall or handshake; every access completes in one cycle.

Test Plan:
- Reset with io_btn_i=4'hF: all outputs 0, DEBOUNCE reads 1000. Release reset with a stable press and DEBOUNCE still 1000 → level bit set exactly at edge 1003.
- Write DEBOUNCE=4, set io_sw_i=32'hA5A5_1234, read 0x7800 → 32'hA5A5_1234 on the read cycle after the sync delay. Read 0x7820 → 0.
- DEBOUNCE=4, btn0 glitches high for 3 cycles → no event, level stays 0. Hold high → BTN_LEVEL=1 and BTN_EVENT=1 at edge 7 after the input change.
- Bounce: release btn0 for 2 cycles inside HELD → returns to HELD and BTN_EVENT remains the single flag. Write 0x7814=1 → reads 0. A full release then re-press → BTN_EVENT=1 again.
- IRQ_EN=4'b0010, press btn0 then btn1 → o_irq stays 0 after btn0 and rises the cycle after btn1's event. W1C 4'b0010 → o_irq falls one cycle later. Issue W1C on the same cycle a new btn1 event sets → bit stays 1.
- During PRESS_CHK with cnt=10 and DEBOUNCE=100, write DEBOUNCE=2 → HELD on the next edge. Assert reset mid-count → IDLE, no event after release.
